// File: rtl/t02_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package t02_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    // Offset applied to every data-port address before it reaches the bus
    localparam logic [31:0] DMEM_BASE = 32'h33000000;
    // Maximum number of bus wait cycles before a transaction is abandoned
    localparam logic [7:0]  TIMEOUT   = 8'd255;
    // Read data returned to the requester when a transaction times out
    localparam logic [31:0] ERR_RDATA = 32'hFFFFFFFF;

endpackage

// File: rtl/t02_mem_arbiter_if.sv
// Shared external memory bus: the arbiter is the master, the memory the slave.
interface t02_mem_arbiter_if;

    logic        bus_cyc;
    logic        bus_we;
    logic [31:0] bus_adr;
    logic [31:0] bus_wdat;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdat;
    logic        bus_err;

    modport master (
        output bus_cyc, bus_we, bus_adr, bus_wdat, bus_sel, bus_err,
        input  bus_ack, bus_rdat
    );

    modport slave (
        input  bus_cyc, bus_we, bus_adr, bus_wdat, bus_sel, bus_err,
        output bus_ack, bus_rdat
    );

endinterface

// File: rtl/t02_bus_timeout.sv
// Per-transaction watchdog: counts bus wait cycles, flags the final allowed one.
module t02_bus_timeout
    import t02_mem_pkg::*;
#(
    parameter logic [7:0] LIMIT = TIMEOUT
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_reg;

    // Wait-cycle counter, restarted at every grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= 8'd0;
        end else if (clr) begin
            count_reg <= 8'd0;
        end else if (en) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // Asserted in the wait cycle whose increment makes the count reach LIMIT,
    // so the bus cycle is held for exactly LIMIT unacknowledged cycles
    assign expired = en && (count_reg == (LIMIT - 8'd1));

endmodule

// File: rtl/t02_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch and data ports.
module t02_mem_arbiter
    import t02_mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sel,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    t02_mem_arbiter_if.master bus
);

    arb_state_t  state_reg, state_next;
    logic        last_was_data_reg;
    logic        bus_cyc_reg, bus_we_reg, bus_err_reg;
    logic [31:0] bus_adr_reg, bus_wdat_reg;
    logic [3:0]  bus_sel_reg;
    logic [31:0] i_rdata_reg, d_rdata_reg;
    logic        i_ready_reg, d_ready_reg;

    logic        in_bus, grant, start_cyc, finish_ack, finish_to;
    logic        to_en, to_expired;

    assign to_en = bus_cyc_reg && !bus.bus_ack;

    t02_bus_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (grant),
        .en      (to_en),
        .expired (to_expired)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: data beats fetch unless the previous grant went to data
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (last_was_data_reg && i_req) begin
                    state_next = IFETCH;
                end else if (d_wen) begin
                    state_next = DWRITE;
                end else if (d_ren) begin
                    state_next = DREAD;
                end else if (i_req) begin
                    state_next = IFETCH;
                end
            end
            IFETCH, DREAD, DWRITE: begin
                if (bus_cyc_reg && (bus.bus_ack || to_expired)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes derived from the current state
    always_comb begin
        in_bus     = (state_reg == IFETCH) || (state_reg == DREAD) || (state_reg == DWRITE);
        grant      = (state_reg == IDLE) && (state_next != IDLE);
        start_cyc  = in_bus && !bus_cyc_reg;
        finish_ack = in_bus && bus_cyc_reg && bus.bus_ack;
        finish_to  = in_bus && bus_cyc_reg && to_expired;
    end

    // Datapath: capture request at grant, run the bus cycle, return the result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_was_data_reg <= 1'b0;
            bus_cyc_reg       <= 1'b0;
            bus_we_reg        <= 1'b0;
            bus_err_reg       <= 1'b0;
            bus_adr_reg       <= 32'd0;
            bus_wdat_reg      <= 32'd0;
            bus_sel_reg       <= 4'd0;
            i_rdata_reg       <= 32'd0;
            d_rdata_reg       <= 32'd0;
            i_ready_reg       <= 1'b0;
            d_ready_reg       <= 1'b0;
        end else begin
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            if (grant) begin
                if (state_next == IFETCH) begin
                    bus_adr_reg       <= i_addr;
                    bus_sel_reg       <= 4'hF;
                    bus_wdat_reg      <= 32'd0;
                    last_was_data_reg <= 1'b0;
                end else begin
                    bus_adr_reg       <= d_addr + DMEM_BASE;
                    bus_sel_reg       <= d_sel;
                    bus_wdat_reg      <= (state_next == DWRITE) ? d_wdata : 32'd0;
                    last_was_data_reg <= 1'b1;
                end
            end
            if (start_cyc) begin
                bus_cyc_reg <= 1'b1;
                bus_we_reg  <= (state_reg == DWRITE);
            end
            if (finish_ack || finish_to) begin
                bus_cyc_reg <= 1'b0;
                bus_we_reg  <= 1'b0;
                if (state_reg == IFETCH) begin
                    i_ready_reg <= 1'b1;
                    i_rdata_reg <= finish_to ? ERR_RDATA : bus.bus_rdat;
                end else begin
                    d_ready_reg <= 1'b1;
                    if (finish_to || (state_reg == DREAD)) begin
                        d_rdata_reg <= finish_to ? ERR_RDATA : bus.bus_rdat;
                    end
                end
            end
            if (finish_to) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign bus.bus_cyc  = bus_cyc_reg;
    assign bus.bus_we   = bus_we_reg;
    assign bus.bus_adr  = bus_adr_reg;
    assign bus.bus_wdat = bus_wdat_reg;
    assign bus.bus_sel  = bus_sel_reg;
    assign bus.bus_err  = bus_err_reg;
    assign i_rdata      = i_rdata_reg;
    assign i_ready      = i_ready_reg;
    assign d_rdata      = d_rdata_reg;
    assign d_ready      = d_ready_reg;

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Randomized bench for t02_mem_arbiter with a request-level reference model.
module tb_t02_mem_arbiter;

    localparam logic [31:0] BASE = 32'h33000000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_req, d_ren, d_wen, i_ready, d_ready;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel;

    t02_mem_arbiter_if bus_if ();

    t02_mem_arbiter dut (
        .CLK     (CLK),
        .RST     (RST),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_ren   (d_ren),
        .d_wen   (d_wen),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_sel   (d_sel),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .bus     (bus_if)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model: which requests are pending, who was served last, sticky error
    bit pend_f, pend_r, pend_w, last_data, err_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0 = fetch, 1 = data read, 2 = data write
    function automatic int pick();
        if (last_data && pend_f) return 0;
        if (pend_w) return 2;
        if (pend_r) return 1;
        return 0;
    endfunction

    // Called at a negedge while the arbiter is idle; returns at the next idle negedge
    task automatic step(input bit af, input bit ar, input bit aw,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] dw, input logic [3:0] ds, input int n);
        int          g;
        logic [31:0] e_adr, e_wdat, rdat;
        logic [3:0]  e_sel;
        if (af && !pend_f) begin
            i_addr = ia; i_req = 1'b1; pend_f = 1'b1;
        end
        if ((ar || aw) && !pend_r && !pend_w) begin
            d_addr = da; d_wdata = dw; d_sel = ds;
            if (ar) begin d_ren = 1'b1; pend_r = 1'b1; end
            if (aw) begin d_wen = 1'b1; pend_w = 1'b1; end
        end
        if (!(pend_f || pend_r || pend_w)) return;
        g      = pick();
        e_adr  = (g == 0) ? i_addr : d_addr + BASE;
        e_sel  = (g == 0) ? 4'hF : d_sel;
        e_wdat = d_wdata;
        rdat   = $urandom;
        txn++;
        $display("txn %0d grant=%0d adr=%h sel=%h waits=%0d", txn, g, e_adr, e_sel, n);

        @(negedge CLK);
        chk("cyc_setup", {31'd0, bus_if.bus_cyc}, 32'd0);
        // Requester changes after the grant must not reach the bus
        if (g == 0) i_addr = $urandom;
        else begin d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom); end

        @(negedge CLK);
        chk("cyc_up", {31'd0, bus_if.bus_cyc}, 32'd1);
        chk("adr", bus_if.bus_adr, e_adr);
        chk("sel", {28'd0, bus_if.bus_sel}, {28'd0, e_sel});
        chk("we", {31'd0, bus_if.bus_we}, (g == 2) ? 32'd1 : 32'd0);
        if (g == 2) chk("wdat", bus_if.bus_wdat, e_wdat);
        chk("err", {31'd0, bus_if.bus_err}, {31'd0, err_exp});
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            chk("wait_cyc", {31'd0, bus_if.bus_cyc}, 32'd1);
            chk("wait_adr", bus_if.bus_adr, e_adr);
            chk("wait_rdy", {30'd0, i_ready, d_ready}, 32'd0);
        end
        bus_if.bus_ack  = 1'b1;
        bus_if.bus_rdat = rdat;

        @(negedge CLK);
        bus_if.bus_ack = 1'b0;
        chk("i_ready", {31'd0, i_ready}, (g == 0) ? 32'd1 : 32'd0);
        chk("d_ready", {31'd0, d_ready}, (g == 0) ? 32'd0 : 32'd1);
        if (g == 0) chk("i_rdata", i_rdata, rdat);
        if (g == 1) chk("d_rdata", d_rdata, rdat);
        chk("cyc_down", {30'd0, bus_if.bus_cyc, bus_if.bus_we}, 32'd0);
        case (g)
            0:       begin i_req = 1'b0; pend_f = 1'b0; last_data = 1'b0; end
            1:       begin d_ren = 1'b0; pend_r = 1'b0; last_data = 1'b1; end
            default: begin d_wen = 1'b0; pend_w = 1'b0; last_data = 1'b1; end
        endcase

        @(negedge CLK);
        chk("pulse_len", {30'd0, i_ready, d_ready}, 32'd0);
    endtask

    initial begin
        int  cyc_cnt;
        bit  seen;
        int  r;
        RST = 1'b1;
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdat = '0;
        pend_f = 0; pend_r = 0; pend_w = 0; last_data = 0; err_exp = 0;

        repeat (3) @(negedge CLK);
        chk("rst_cyc", {30'd0, bus_if.bus_cyc, bus_if.bus_we}, 32'd0);
        chk("rst_adr", bus_if.bus_adr, 32'd0);
        chk("rst_rdy", {29'd0, i_ready, d_ready, bus_if.bus_err}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Fetch with ack in the second bus cycle
        step(1, 0, 0, 32'h00000010, 32'd0, 32'd0, 4'h0, 1);
        // Contention: read first, then the held fetch, then the next read
        step(1, 1, 0, 32'h00000020, 32'h00000100, 32'd0, 4'hF, 0);
        step(0, 1, 0, 32'd0, 32'h00000200, 32'd0, 4'hC, 2);
        step(0, 0, 0, 32'd0, 32'd0, 32'd0, 4'h0, 0);
        // Store
        step(0, 0, 1, 32'd0, 32'h00000004, 32'hDEADBEEF, 4'h3, 0);
        // Address wrap
        step(0, 1, 0, 32'd0, 32'hCD000000, 32'd0, 4'hF, 1);
        // Write and read raised together: write wins
        step(0, 1, 1, 32'd0, 32'h00000040, 32'h12345678, 4'h5, 0);
        step(0, 0, 0, 32'd0, 32'd0, 32'd0, 4'h0, 0);

        for (int it = 0; it < 40; it++) begin
            bit af;
            af = 1'($urandom);
            r  = $urandom_range(0, 3);
            if (!(pend_f || pend_r || pend_w) && !af && r == 0) af = 1'b1;
            step(af, (r == 1) || (r == 3), (r == 2) || (r == 3),
                 $urandom, $urandom, $urandom, 4'($urandom), $urandom_range(0, 3));
        end
        for (int k = 0; k < 4 && (pend_f || pend_r || pend_w); k++)
            step(0, 0, 0, 32'd0, 32'd0, 32'd0, 4'h0, 0);

        // Timeout: read with no acknowledge
        d_addr = 32'h00000010; d_sel = 4'hF; d_ren = 1'b1;
        cyc_cnt = 0; seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge CLK);
            if (d_ready) seen = 1;
            else if (bus_if.bus_cyc) cyc_cnt++;
        end
        $display("txn timeout cycles=%0d ready_seen=%0d", cyc_cnt, seen);
        chk("to_seen", {31'd0, seen}, 32'd1);
        chk("to_cycles", cyc_cnt, 32'd255);
        chk("to_rdata", d_rdata, 32'hFFFFFFFF);
        chk("to_err", {31'd0, bus_if.bus_err}, 32'd1);
        chk("to_cyc", {30'd0, bus_if.bus_cyc, i_ready}, 32'd0);
        d_ren = 1'b0; last_data = 1'b1; err_exp = 1'b1;
        @(negedge CLK);
        chk("to_pulse", {31'd0, d_ready}, 32'd0);
        step(1, 0, 0, 32'h00000400, 32'd0, 32'd0, 4'h0, 0);
        step(0, 0, 1, 32'd0, 32'h00000008, 32'hCAFEF00D, 4'hF, 1);

        // Reset while the bus cycle is active
        i_addr = 32'h00000080; i_req = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rm_pre_cyc", {31'd0, bus_if.bus_cyc}, 32'd1);
        RST = 1'b1;
        #1;
        chk("rm_cyc", {31'd0, bus_if.bus_cyc}, 32'd0);
        i_req = 1'b0;
        pend_f = 0; pend_r = 0; pend_w = 0; last_data = 0; err_exp = 0;
        @(negedge CLK);
        chk("rm_rdy", {30'd0, i_ready, d_ready}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rm_rdy2", {30'd0, i_ready, d_ready}, 32'd0);
        chk("rm_bus", {29'd0, bus_if.bus_cyc, bus_if.bus_we, bus_if.bus_err}, 32'd0);
        chk("rm_adr", bus_if.bus_adr | bus_if.bus_wdat | {28'd0, bus_if.bus_sel}, 32'd0);
        chk("rm_rdata", i_rdata | d_rdata, 32'd0);
        step(1, 0, 0, 32'h00000100, 32'd0, 32'd0, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
